program_loader: RTL

Boot-time program loader that owns the instruction-memory write port and the processor's reset. It receives a length-prefixed byte stream over a valid/ready interface, assembles big-endian 32-bit instruction words, and writes them to consecutive instruction-memory word addresses. The processor (`MIPS_Single_Cycle`) is held in reset until the image is fully written. This makes it the write side of the instruction memory that the core fetches from.

---
 rtl/program_loader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader
//
// Boot-time loader that owns the instruction-memory write port and the
// processor reset. A length-prefixed byte stream arrives over a valid/ready
// handshake. The first two bytes are the word count N, MSB first. N big-endian
// 32-bit words follow, and each one is written to consecutive word addresses
// starting at 0. The processor stays in reset until the whole image is written.
//
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing
// 4-byte checksum. It is compared against the mod-2^32 sum of all words. A
// mismatch ends in the error state with the processor still held in reset.
//
// Parameters:
//   ADDR_WIDTH   instruction-memory word-address width (at most 16)
//   MAX_WORDS    largest accepted image in words (at most 2^ADDR_WIDTH)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   start         single-cycle pulse that begins a load from IDLE/DONE/ERR
//   rx_data       stream byte
//   rx_valid      rx_data is valid
//   rx_ready      loader accepts a byte this cycle
//   imem_we       one-cycle instruction-memory write strobe
//   imem_addr     word address of the write
//   imem_wdata    instruction word being written
//   cpu_reset     processor reset, low only once an image is fully loaded
//   busy          load in progress
//   done          image loaded (sticky until the next start)
//   error         load aborted (sticky until the next start)
//   words_loaded  words written so far in the current load
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_HI = 3'd1;
    localparam logic [2:0] LEN_LO = 3'd2;
    localparam logic [2:0] BYTE   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] CHECK  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [2:0] ERR    = 3'd7;

    // With the checksum enabled, every successful load passes through CHECK
    // before it reaches DONE.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] FINISH = CHECK;
`else
    localparam logic [2:0] FINISH = DONE;
`endif

    logic [2:0]            state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           shift_q, shift_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           count_q, count_d;
    logic                  rx_ready_q, busy_q, done_q, error_q, cpu_reset_q, we_q;
    logic                  xfer;
    logic [15:0]           len_full;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0]           sum_q, sum_d;
`endif

    assign xfer     = rx_valid && rx_ready_q;
    assign len_full = {len_q[15:8], rx_data};

    // Next-state logic.
    // Bytes shift into a 24-bit holding register. The fourth byte of each word
    // is combined with it directly, so a complete word is ready on the edge
    // that accepts its last byte.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        count_d    = count_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN_HI;
                    count_d    = '0;
                    byte_cnt_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = rx_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = rx_data;
                    if (32'(len_full) > MAX_WORDS) begin
                        state_d = ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = BYTE;
                    end
                end
            end
            BYTE: begin
                if (xfer) begin
                    shift_d    = {shift_q[15:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wdata_d = {shift_q, rx_data};
                        addr_d  = count_q[ADDR_WIDTH-1:0];
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                count_d = count_q + 16'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                sum_d   = sum_q + wdata_q;
`endif
                if (count_q + 16'd1 == len_q) begin
                    state_d = FINISH;
                end else begin
                    state_d = BYTE;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    shift_d    = {shift_q[15:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ({shift_q, rx_data} == sum_q) ? DONE : ERR;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    // Every status output is decoded from the next state, so each output
    // changes on the same edge as the state it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            rx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            we_q        <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            rx_ready_q  <= (state_d == LEN_HI) || (state_d == LEN_LO) ||
                           (state_d == BYTE)   || (state_d == CHECK);
            busy_q      <= !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
            done_q      <= (state_d == DONE);
            error_q     <= (state_d == ERR);
            cpu_reset_q <= (state_d != DONE);
            we_q        <= (state_d == WRITE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign rx_ready     = rx_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_reset    = cpu_reset_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = count_q;

endmodule
